// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS UART debug bridge: command bytes,
// FSM state codes shown on the LEDs, and dump item kinds.
package mips_debug_pkg;

    // One-byte commands received from the UART
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'
    localparam logic [7:0] CMD_HALT = 8'h68;  // 'h', only meaningful while running

    // State codes as reported on o_state_debug
    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StStep   = 4'd1,
        StRun    = 4'd2,
        StLoad   = 4'd3,
        StSend   = 4'd4,
        StWaitTx = 4'd5,
        StNext   = 4'd6
    } dbg_state_e;

    // Serializer handshake phases
    typedef enum logic [1:0] {
        SerIdle,
        SerSend,
        SerWait
    } ser_state_e;

    // What a given dump slot carries
    typedef enum logic [2:0] {
        ItemPc,
        ItemAlu,
        ItemReg,
        ItemMem,
        ItemCyc
    } item_kind_e;

    // Map a dump index onto its item kind: PC, ALU, registers, memory, then cycle count
    function automatic item_kind_e item_kind(input int unsigned idx,
                                             input int unsigned n_regs,
                                             input int unsigned mem_words);
        if (idx == 0) return ItemPc;
        if (idx == 1) return ItemAlu;
        if (idx < 2 + n_regs) return ItemReg;
        if (idx < 2 + n_regs + mem_words) return ItemMem;
        return ItemCyc;
    endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Sends one NB-bit word over the UART byte interface, LSB byte first.
// A load captures the word; each byte is offered with a one-cycle start
// pulse and shifted out once the transmitter reports it finished.
module debug_word_serializer import mips_debug_pkg::*; #(
    parameter int unsigned NB        = 32,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic [NB-1:0]        i_word,
    input  logic                 i_tx_done,
    output logic                 o_tx_ready,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_busy,
    output logic                 o_wait,
    output logic                 o_done
);

    localparam int unsigned BYTES = NB / DATA_BITS;
    localparam int unsigned CW    = $clog2(BYTES) + 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);

    ser_state_e    state_q;
    logic [NB-1:0] shreg_q;
    logic [CW-1:0] cnt_q;

    // Load / send / wait-for-done handshake with the shift register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= SerIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                SerIdle: begin
                    if (i_load) begin
                        shreg_q <= i_word;
                        cnt_q   <= '0;
                        state_q <= SerSend;
                    end
                end
                SerSend: state_q <= SerWait;
                SerWait: begin
                    if (i_tx_done) begin
                        shreg_q <= shreg_q >> DATA_BITS;
                        if (cnt_q == LAST_BYTE) begin
                            cnt_q   <= '0;
                            state_q <= SerIdle;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                            state_q <= SerSend;
                        end
                    end
                end
                default: state_q <= SerIdle;
            endcase
        end
    end

    // Shifted-out register is all zeros once a word completes, so tx_data idles at 0
    assign o_tx_ready = (state_q == SerSend);
    assign o_tx_data  = shreg_q[DATA_BITS-1:0];
    assign o_busy     = (state_q != SerIdle);
    assign o_wait     = (state_q == SerWait);
    assign o_done     = (state_q == SerWait) && i_tx_done && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/mips_debug_bridge.sv
// UART debug controller for the MIPS pipeline. Decodes step/run/dump
// commands, gates the pipeline clock enable, then streams PC, ALU result,
// register file and a data-memory window to the transmitter.
// Optional build macro: DEBUG_CYCLE_COUNT_EN appends a count of stepped
// cycles as the final dump word.
module mips_debug_bridge import mips_debug_pkg::*; #(
    parameter int unsigned NB        = 32,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned N_REGS    = 32,
    parameter int unsigned MEM_WORDS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_uart_rx_ready,
    input  logic [DATA_BITS-1:0] i_uart_rx_data,
    input  logic                 i_uart_tx_done,
    input  logic [NB-1:0]        i_mips_pc,
    input  logic [NB-1:0]        i_mips_alu_result,
    input  logic [NB-1:0]        i_mips_register,
    input  logic [NB-1:0]        i_mips_mem_data,
    input  logic                 i_halt,
    output logic                 o_uart_tx_ready,
    output logic [DATA_BITS-1:0] o_uart_tx_data,
    output logic                 o_step,
    output logic [3:0]           o_state_debug,
    output logic [NB-1:0]        o_mips_register_number,
    output logic [NB-1:0]        o_mips_memory_address
);

`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int unsigned N_ITEMS = N_REGS + MEM_WORDS + 3;
`else
    localparam int unsigned N_ITEMS = N_REGS + MEM_WORDS + 2;
`endif
    localparam int unsigned IW = $clog2(N_ITEMS) + 1;
    localparam logic [IW-1:0] LAST_ITEM = IW'(N_ITEMS - 1);

    dbg_state_e    state_q;
    logic          step_q;
    logic          settle_q;
    logic [IW-1:0] item_q;
    logic [NB-1:0] reg_num_q;
    logic [NB-1:0] mem_addr_q;

    item_kind_e    kind;
    logic [NB-1:0] word;
    logic          ser_load;
    logic          ser_busy;
    logic          ser_wait;
    logic          ser_done;

    logic rx_step, rx_run, rx_dump, rx_halt;
    assign rx_step = i_uart_rx_ready && (i_uart_rx_data == DATA_BITS'(CMD_STEP));
    assign rx_run  = i_uart_rx_ready && (i_uart_rx_data == DATA_BITS'(CMD_RUN));
    assign rx_dump = i_uart_rx_ready && (i_uart_rx_data == DATA_BITS'(CMD_DUMP));
    assign rx_halt = i_uart_rx_ready && (i_uart_rx_data == DATA_BITS'(CMD_HALT));

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [NB-1:0] cyc_q;

    // Count every cycle the pipeline was enabled; only reset clears it
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cyc_q <= '0;
        end else if (step_q) begin
            cyc_q <= cyc_q + NB'(1);
        end
    end
`endif

    // Classify the current dump slot
    always_comb begin
        kind = item_kind(32'(item_q), N_REGS, MEM_WORDS);
    end

    // Select the word for the current dump slot
    always_comb begin
        word = '0;
        unique case (kind)
            ItemPc:  word = i_mips_pc;
            ItemAlu: word = i_mips_alu_result;
            ItemReg: word = i_mips_register;
            ItemMem: word = i_mips_mem_data;
`ifdef DEBUG_CYCLE_COUNT_EN
            ItemCyc: word = cyc_q;
`endif
            default: word = '0;
        endcase
    end

    // Capture on the second LOAD cycle, after the readback address has settled
    assign ser_load = (state_q == StLoad) && settle_q && !ser_busy;

    // Command decode, step gating and dump sequencing
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            step_q     <= 1'b0;
            settle_q   <= 1'b0;
            item_q     <= '0;
            reg_num_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rx_step) begin
                        step_q  <= 1'b1;
                        state_q <= StStep;
                    end else if (rx_run) begin
                        // Already halted: skip stepping entirely
                        if (i_halt) begin
                            state_q <= StLoad;
                        end else begin
                            step_q  <= 1'b1;
                            state_q <= StRun;
                        end
                    end else if (rx_dump) begin
                        state_q <= StLoad;
                    end
                end
                StStep: begin
                    step_q  <= 1'b0;
                    state_q <= StLoad;
                end
                StRun: begin
                    if (i_halt || rx_halt) begin
                        step_q  <= 1'b0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (!settle_q) begin
                        settle_q <= 1'b1;
                        if (kind == ItemReg) begin
                            reg_num_q <= NB'(item_q - IW'(2));
                        end
                        if (kind == ItemMem) begin
                            mem_addr_q <= NB'(item_q - IW'(2 + N_REGS)) << 2;
                        end
                    end else if (ser_load) begin
                        settle_q <= 1'b0;
                        state_q  <= StSend;
                    end
                end
                StSend: begin
                    if (ser_done) begin
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (item_q == LAST_ITEM) begin
                        item_q     <= '0;
                        reg_num_q  <= '0;
                        mem_addr_q <= '0;
                        state_q    <= StIdle;
                    end else begin
                        item_q  <= item_q + IW'(1);
                        state_q <= StLoad;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    debug_word_serializer #(
        .NB        (NB),
        .DATA_BITS (DATA_BITS)
    ) u_serializer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_word     (word),
        .i_tx_done  (i_uart_tx_done),
        .o_tx_ready (o_uart_tx_ready),
        .o_tx_data  (o_uart_tx_data),
        .o_busy     (ser_busy),
        .o_wait     (ser_wait),
        .o_done     (ser_done)
    );

    // The serializer phase splits the top-level SEND state into SEND / WAIT_TX
    assign o_state_debug          = (state_q == StSend && ser_wait) ? StWaitTx : state_q;
    assign o_step                 = step_q;
    assign o_mips_register_number = reg_num_q;
    assign o_mips_memory_address  = mem_addr_q;

endmodule
